// File: rtl/simmem_linkedlist_bank_pkg.sv
// Shared sizing constants and types for the simulated-memory response banks.
package simmem_linkedlist_bank_pkg;

   localparam int unsigned XRespWidth        = 8;
   localparam int unsigned BankIdWidth       = 4;
   localparam int unsigned BankTotalCapacity = 32;
   localparam int unsigned BankAddrWidth     = $clog2(BankTotalCapacity);

   typedef struct packed {
      logic [BankAddrWidth-1:0] nxt_elem;
   } linkedlist_meta_t;

endpackage

// File: rtl/simmem_free_slot_finder.sv
// Lowest-index set-bit finder; used for free-slot allocation and lowest-ID arbitration.
module simmem_free_slot_finder #(
   parameter int unsigned Width    = 32,
   localparam int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
   input  logic [Width-1:0]    bitmap_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                any_o
);

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = Width - 1; i >= 0; i--) begin
         idx_o = bitmap_i[i] ? IdxWidth'(i) : idx_o;
         any_o = any_o | bitmap_i[i];
      end
   end

endmodule

// File: rtl/simmem_linkedlist_bank_chk.sv
// Consistency checks on the bank bookkeeping: slot conservation and count ordering.
module simmem_linkedlist_bank_chk #(
   parameter int unsigned NumIds        = 16,
   parameter int unsigned TotalCapacity = 32,
   parameter int unsigned CntWidth      = 6,
   parameter int unsigned AddrWidth     = 5
) (
   input logic                     clk_i,
   input logic                     rst_i,
   input logic [TotalCapacity-1:0] free_i,
   input logic [CntWidth-1:0]      res_cnt_i [NumIds],
   input logic [CntWidth-1:0]      fil_cnt_i [NumIds],
   input logic                     res_hs_i,
   input logic [AddrWidth-1:0]     res_slot_i
);

   int   occupied_s;
   logic cnt_ok_s;

   // Sum reserved slots over all lists and check filled never exceeds reserved.
   always_comb begin
      occupied_s = 0;
      cnt_ok_s   = 1'b1;
      for (int i = 0; i < int'(NumIds); i++) begin
         occupied_s = occupied_s + int'(res_cnt_i[i]);
         cnt_ok_s   = cnt_ok_s & (fil_cnt_i[i] <= res_cnt_i[i]);
      end
   end

   // Sampled every active edge outside reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!res_hs_i || free_i[res_slot_i]);
         assert (cnt_ok_s);
         assert ($countones(free_i) + occupied_s == int'(TotalCapacity));
      end
   end

endmodule

// File: rtl/simmem_linkedlist_bank.sv
// Response bank: one linked list per AXI ID threaded through a shared slot RAM.
module simmem_linkedlist_bank
   import simmem_linkedlist_bank_pkg::*;
#(
   parameter int unsigned IDWidth       = BankIdWidth,
   parameter int unsigned TotalCapacity = BankTotalCapacity,
   parameter int unsigned DataWidth     = XRespWidth,
   localparam int unsigned NumIds    = 2**IDWidth,
   localparam int unsigned AddrWidth = $clog2(TotalCapacity),
   localparam int unsigned CntWidth  = $clog2(TotalCapacity + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 res_valid_i,
   input  logic [IDWidth-1:0]   res_id_i,
   output logic                 res_ready_o,
   output logic [AddrWidth-1:0] res_addr_o,
   input  logic                 in_valid_i,
   input  logic [IDWidth-1:0]   in_id_i,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 in_ready_o,
   input  logic [NumIds-1:0]    release_en_i,
   output logic                 out_valid_o,
   output logic [IDWidth-1:0]   out_id_o,
   output logic [DataWidth-1:0] out_data_o,
   input  logic                 out_ready_i
);

   logic [TotalCapacity-1:0] free_q, free_d;
   logic [TotalCapacity-1:0] filled_q, filled_d;
   logic [DataWidth-1:0]     data_q [TotalCapacity];
   logic [DataWidth-1:0]     data_d [TotalCapacity];
   logic [AddrWidth-1:0]     nxt_q [TotalCapacity];
   logic [AddrWidth-1:0]     nxt_d [TotalCapacity];
   logic [AddrWidth-1:0]     head_q [NumIds];
   logic [AddrWidth-1:0]     head_d [NumIds];
   logic [AddrWidth-1:0]     tail_q [NumIds];
   logic [AddrWidth-1:0]     tail_d [NumIds];
   logic [AddrWidth-1:0]     fill_q [NumIds];
   logic [AddrWidth-1:0]     fill_d [NumIds];
   logic [CntWidth-1:0]      res_cnt_q [NumIds];
   logic [CntWidth-1:0]      res_cnt_d [NumIds];
   logic [CntWidth-1:0]      fil_cnt_q [NumIds];
   logic [CntWidth-1:0]      fil_cnt_d [NumIds];

   logic [AddrWidth-1:0] res_slot_s, fill_slot_s, out_slot_s;
   logic [NumIds-1:0]    cand_s;
   logic [IDWidth-1:0]   out_id_s;
   logic                 any_free_s, out_any_s;
   logic                 res_hs_s, in_hs_s, out_hs_s;
   logic                 res_empty_s;
   logic [CntWidth-1:0]  res_pend_s;

   simmem_free_slot_finder #(.Width(TotalCapacity)) u_slot_finder (
      .bitmap_i (free_q),
      .idx_o    (res_slot_s),
      .any_o    (any_free_s)
   );

   simmem_free_slot_finder #(.Width(NumIds)) u_id_arbiter (
      .bitmap_i (cand_s),
      .idx_o    (out_id_s),
      .any_o    (out_any_s)
   );

   // A list may be released only when its head slot already holds data.
   always_comb begin
      cand_s = '0;
      for (int i = 0; i < int'(NumIds); i++) begin
         cand_s[i] = release_en_i[i] & (res_cnt_q[i] != '0) & filled_q[head_q[i]];
      end
   end

   assign res_ready_o = any_free_s;
   assign res_addr_o  = res_slot_s;
   assign in_ready_o  = res_cnt_q[in_id_i] != fil_cnt_q[in_id_i];
   assign out_valid_o = out_any_s;
   assign out_id_o    = out_id_s;
   assign out_slot_s  = head_q[out_id_s];
   assign out_data_o  = data_q[out_slot_s];
   assign fill_slot_s = fill_q[in_id_i];

   assign res_hs_s = res_valid_i & any_free_s;
   assign in_hs_s  = in_valid_i & in_ready_o;
   assign out_hs_s = out_any_s & out_ready_i;

   // Same-ID release or fill in the reservation cycle changes what "empty" and "all filled" mean.
   assign res_empty_s = res_cnt_q[res_id_i] == CntWidth'(out_hs_s && (out_id_s == res_id_i));
   assign res_pend_s  = res_cnt_q[res_id_i] - fil_cnt_q[res_id_i]
                        - CntWidth'(in_hs_s && (in_id_i == res_id_i));

   // Next-state for slot RAM and per-ID list pointers; reservation is applied last so it wins.
   always_comb begin
      free_d   = free_q;
      filled_d = filled_q;
      data_d   = data_q;
      nxt_d    = nxt_q;
      head_d   = head_q;
      tail_d   = tail_q;
      fill_d   = fill_q;
      for (int i = 0; i < int'(NumIds); i++) begin
         res_cnt_d[i] = res_cnt_q[i] + CntWidth'(res_hs_s && (res_id_i == IDWidth'(i)))
                        - CntWidth'(out_hs_s && (out_id_s == IDWidth'(i)));
         fil_cnt_d[i] = fil_cnt_q[i] + CntWidth'(in_hs_s && (in_id_i == IDWidth'(i)))
                        - CntWidth'(out_hs_s && (out_id_s == IDWidth'(i)));
      end
      if (out_hs_s) begin
         free_d[out_slot_s]   = 1'b1;
         filled_d[out_slot_s] = 1'b0;
         head_d[out_id_s]     = nxt_q[out_slot_s];
      end else begin
         head_d[out_id_s] = head_q[out_id_s];
      end
      if (in_hs_s) begin
         data_d[fill_slot_s]   = in_data_i;
         filled_d[fill_slot_s] = 1'b1;
         fill_d[in_id_i]       = nxt_q[fill_slot_s];
      end else begin
         fill_d[in_id_i] = fill_q[in_id_i];
      end
      if (res_hs_s) begin
         free_d[res_slot_s] = 1'b0;
         tail_d[res_id_i]   = res_slot_s;
         if (res_empty_s) begin
            head_d[res_id_i] = res_slot_s;
         end else begin
            nxt_d[tail_q[res_id_i]] = res_slot_s;
         end
         fill_d[res_id_i] = (res_pend_s == '0) ? res_slot_s : fill_d[res_id_i];
      end else begin
         tail_d[res_id_i] = tail_q[res_id_i];
      end
   end

   // State registers; reset empties every list and frees every slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         free_q    <= '1;
         filled_q  <= '0;
         data_q    <= '{default: '0};
         nxt_q     <= '{default: '0};
         head_q    <= '{default: '0};
         tail_q    <= '{default: '0};
         fill_q    <= '{default: '0};
         res_cnt_q <= '{default: '0};
         fil_cnt_q <= '{default: '0};
      end else begin
         free_q    <= free_d;
         filled_q  <= filled_d;
         data_q    <= data_d;
         nxt_q     <= nxt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         fill_q    <= fill_d;
         res_cnt_q <= res_cnt_d;
         fil_cnt_q <= fil_cnt_d;
      end
   end

   simmem_linkedlist_bank_chk #(
      .NumIds        (NumIds),
      .TotalCapacity (TotalCapacity),
      .CntWidth      (CntWidth),
      .AddrWidth     (AddrWidth)
   ) u_chk (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .free_i     (free_q),
      .res_cnt_i  (res_cnt_q),
      .fil_cnt_i  (fil_cnt_q),
      .res_hs_i   (res_hs_s),
      .res_slot_i (res_slot_s)
   );

endmodule

// File: tb/tb_simmem_linkedlist_bank.sv
// Directed, table-driven bench for the linked-list response bank.
module tb_simmem_linkedlist_bank;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        res_valid_i;
   logic [3:0]  res_id_i;
   logic        res_ready_o;
   logic [4:0]  res_addr_o;
   logic        in_valid_i;
   logic [3:0]  in_id_i;
   logic [7:0]  in_data_i;
   logic        in_ready_o;
   logic [15:0] release_en_i;
   logic        out_valid_o;
   logic [3:0]  out_id_o;
   logic [7:0]  out_data_o;
   logic        out_ready_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        rv;
      logic [3:0]  rid;
      logic        iv;
      logic [3:0]  iid;
      logic [7:0]  idata;
      logic [15:0] rel;
      logic        ordy;
      logic        e_rrdy;
      logic [4:0]  e_addr;
      logic        e_irdy;
      logic        e_ov;
      logic [3:0]  e_oid;
      logic [7:0]  e_od;
   } vec_t;

   vec_t tbl [$];

   simmem_linkedlist_bank dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .res_valid_i  (res_valid_i),
      .res_id_i     (res_id_i),
      .res_ready_o  (res_ready_o),
      .res_addr_o   (res_addr_o),
      .in_valid_i   (in_valid_i),
      .in_id_i      (in_id_i),
      .in_data_i    (in_data_i),
      .in_ready_o   (in_ready_o),
      .release_en_i (release_en_i),
      .out_valid_o  (out_valid_o),
      .out_id_o     (out_id_o),
      .out_data_o   (out_data_o),
      .out_ready_i  (out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(input string name, input logic rv, input logic [3:0] rid,
                               input logic iv, input logic [3:0] iid, input logic [7:0] idata,
                               input logic [15:0] rel, input logic ordy, input logic e_rrdy,
                               input logic [4:0] e_addr, input logic e_irdy, input logic e_ov,
                               input logic [3:0] e_oid, input logic [7:0] e_od);
      vec_t v;
      v.name = name;  v.rv = rv;     v.rid = rid;       v.iv = iv;         v.iid = iid;
      v.idata = idata; v.rel = rel;  v.ordy = ordy;     v.e_rrdy = e_rrdy; v.e_addr = e_addr;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_oid = e_oid; v.e_od = e_od;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      res_valid_i  = 1'b0;
      res_id_i     = 4'd0;
      in_valid_i   = 1'b0;
      in_id_i      = 4'd0;
      in_data_i    = 8'h00;
      release_en_i = 16'h0000;
      out_ready_i  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      drive_idle();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // One cycle: drive at the falling edge, compare 1 ns later, handshake on the next rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk_i);
      res_valid_i  = v.rv;
      res_id_i     = v.rid;
      in_valid_i   = v.iv;
      in_id_i      = v.iid;
      in_data_i    = v.idata;
      release_en_i = v.rel;
      out_ready_i  = v.ordy;
      #1;
      chk({v.name, "/res_ready"}, 32'(res_ready_o), 32'(v.e_rrdy));
      if (v.rv && v.e_rrdy) chk({v.name, "/res_addr"}, 32'(res_addr_o), 32'(v.e_addr));
      chk({v.name, "/in_ready"}, 32'(in_ready_o), 32'(v.e_irdy));
      chk({v.name, "/out_valid"}, 32'(out_valid_o), 32'(v.e_ov));
      if (v.e_ov) begin
         chk({v.name, "/out_id"}, 32'(out_id_o), 32'(v.e_oid));
         chk({v.name, "/out_data"}, 32'(out_data_o), 32'(v.e_od));
      end
   endtask

   initial begin
      drive_idle();
      rst_i = 1'b1;
      #1;
      chk("reset/res_ready", 32'(res_ready_o), 32'd1);
      chk("reset/res_addr", 32'(res_addr_o), 32'd0);
      chk("reset/in_ready", 32'(in_ready_o), 32'd0);
      chk("reset/out_valid", 32'(out_valid_o), 32'd0);
      chk("reset/out_id", 32'(out_id_o), 32'd0);
      chk("reset/out_data", 32'(out_data_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // In-order release of one ID, then lowest-ID-first interleave.
      //                 name          rv    rid    iv    iid    idata   rel        ordy  rrdy  addr   irdy  ov    oid    od
      tbl.push_back(mk("t1_idle",     1'b0, 4'd0, 1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t1_res0",     1'b1, 4'd3, 1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t1_res1",     1'b1, 4'd3, 1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t1_res2",     1'b1, 4'd3, 1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t1_fillA",    1'b0, 4'd0, 1'b1, 4'd3, 8'h0A, 16'h0008, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t1_fillB",    1'b0, 4'd0, 1'b1, 4'd3, 8'h0B, 16'h0008, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 4'd3, 8'h0A));
      tbl.push_back(mk("t1_fillC",    1'b0, 4'd0, 1'b1, 4'd3, 8'h0C, 16'h0008, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 4'd3, 8'h0A));
      tbl.push_back(mk("t1_outA",     1'b0, 4'd0, 1'b0, 4'd3, 8'h00, 16'h0008, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd3, 8'h0A));
      tbl.push_back(mk("t1_outB",     1'b0, 4'd0, 1'b0, 4'd3, 8'h00, 16'h0008, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd3, 8'h0B));
      tbl.push_back(mk("t1_outC",     1'b0, 4'd0, 1'b0, 4'd3, 8'h00, 16'h0008, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd3, 8'h0C));
      tbl.push_back(mk("t1_empty",    1'b0, 4'd0, 1'b0, 4'd3, 8'h00, 16'h0008, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_res1a",    1'b1, 4'd1, 1'b0, 4'd1, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_res2",     1'b1, 4'd2, 1'b0, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_res1b",    1'b1, 4'd1, 1'b0, 4'd1, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_fill2",    1'b0, 4'd0, 1'b1, 4'd2, 8'h22, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_fill1a",   1'b0, 4'd0, 1'b1, 4'd1, 8'h11, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_fill1b",   1'b0, 4'd0, 1'b1, 4'd1, 8'h12, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      tbl.push_back(mk("t2_out1a",    1'b0, 4'd0, 1'b0, 4'd2, 8'h00, 16'hFFFF, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd1, 8'h11));
      tbl.push_back(mk("t2_out1b",    1'b0, 4'd0, 1'b0, 4'd2, 8'h00, 16'hFFFF, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd1, 8'h12));
      tbl.push_back(mk("t2_out2",     1'b0, 4'd0, 1'b0, 4'd2, 8'h00, 16'hFFFF, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd2, 8'h22));
      tbl.push_back(mk("t2_none",     1'b0, 4'd0, 1'b0, 4'd2, 8'h00, 16'hFFFF, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

      // Full bank on a single ID, one release, freed slot granted the cycle after.
      do_reset();
      for (int i = 0; i < 32; i++)
         apply(mk("t3_fillup", 1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b1, 5'(i), (i > 0), 1'b0, 4'd0, 8'h00));
      apply(mk("t3_full",    1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      apply(mk("t3_fill",    1'b1, 4'd0, 1'b1, 4'd0, 8'h55, 16'h0000, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      apply(mk("t3_rel",     1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 16'h0001, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 4'd0, 8'h55));
      apply(mk("t3_regrant", 1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));

      // Payload with no reservation stalls, then is accepted the cycle after its reservation.
      do_reset();
      for (int i = 0; i < 10; i++)
         apply(mk("t4_stall", 1'b0, 4'd0, 1'b1, 4'd5, 8'h5A, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      apply(mk("t4_res",  1'b1, 4'd5, 1'b1, 4'd5, 8'h5A, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));
      apply(mk("t4_fill", 1'b0, 4'd0, 1'b1, 4'd5, 8'h5A, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      apply(mk("t4_out",  1'b0, 4'd0, 1'b0, 4'd5, 8'h00, 16'h0020, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd5, 8'h5A));

      // Release of the last ID7 entry (slot 4) together with a new ID7 reservation.
      do_reset();
      for (int i = 0; i < 4; i++)
         apply(mk("t5_res0", 1'b1, 4'd0, 1'b0, 4'd7, 8'h00, 16'h0000, 1'b0, 1'b1, 5'(i), 1'b0, 1'b0, 4'd0, 8'h00));
      apply(mk("t5_res7",     1'b1, 4'd7, 1'b0, 4'd7, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 4'd0, 8'h00));
      apply(mk("t5_fill7",    1'b0, 4'd0, 1'b1, 4'd7, 8'h77, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      apply(mk("t5_same",     1'b1, 4'd7, 1'b0, 4'd7, 8'h00, 16'h0080, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 4'd7, 8'h77));
      apply(mk("t5_slot4",    1'b1, 4'd1, 1'b0, 4'd7, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 4'd0, 8'h00));
      apply(mk("t5_fillnew",  1'b0, 4'd0, 1'b1, 4'd7, 8'h78, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      apply(mk("t5_outnew",   1'b0, 4'd0, 1'b0, 4'd7, 8'h00, 16'h0080, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'd7, 8'h78));

      // Asynchronous reset in the middle of a cycle with ten entries outstanding.
      do_reset();
      for (int i = 0; i < 10; i++)
         apply(mk("t6_res", 1'b1, 4'(i % 4), 1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b1, 5'(i), (i > 0), 1'b0, 4'd0, 8'h00));
      apply(mk("t6_fill", 1'b0, 4'd0, 1'b1, 4'd0, 8'h90, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 8'h00));
      @(negedge clk_i);
      res_valid_i  = 1'b1;
      res_id_i     = 4'd2;
      in_valid_i   = 1'b1;
      in_id_i      = 4'd1;
      release_en_i = 16'hFFFF;
      out_ready_i  = 1'b0;
      #1;
      chk("t6_pre/out_valid", 32'(out_valid_o), 32'd1);
      chk("t6_pre/out_data", 32'(out_data_o), 32'h90);
      chk("t6_pre/in_ready", 32'(in_ready_o), 32'd1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("t6_rst/res_ready", 32'(res_ready_o), 32'd1);
      chk("t6_rst/res_addr", 32'(res_addr_o), 32'd0);
      chk("t6_rst/in_ready", 32'(in_ready_o), 32'd0);
      chk("t6_rst/out_valid", 32'(out_valid_o), 32'd0);
      chk("t6_rst/out_id", 32'(out_id_o), 32'd0);
      chk("t6_rst/out_data", 32'(out_data_o), 32'd0);
      @(negedge clk_i);
      drive_idle();
      rst_i = 1'b0;
      apply(mk("t6_after", 1'b1, 4'd2, 1'b0, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'h00));

      @(negedge clk_i);
      drive_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
